// File: rtl/fs_accel_mpctrl.sv
// fs_accel_mpctrl: max-pool window scheduler and lane accumulator.
// Steers a row-major int8 pixel stream into up to NLANES running signed-max
// accumulators, then drains one result per lane after every K-row strip.
// Optional build macro: FS_ACCEL_MPCTRL_RELU_EN (clamps negative drained results to 0).
//
// Handshakes: a pixel transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready is low, out_data/out_lane stay stable.
module fs_accel_mpctrl #(
  parameter int NLANES = 13,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [3:0]    cfg_out_w,
  input  logic [1:0]    cfg_pool,
  input  logic [7:0]    cfg_out_h,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    mp_sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_lane,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Most negative value: identity element for a signed max.
  localparam logic signed [DW-1:0] ACC_INIT = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched job configuration (already clamped).
  logic [3:0] cfg_w;
  logic [1:0] cfg_k;
  logic [7:0] cfg_h;

  // Window position counters and drain/strip counters.
  logic [1:0] kcol;
  logic [3:0] lane;
  logic [1:0] krow;
  logic [7:0] strip;
  logic [3:0] drain_idx;

  logic signed [DW-1:0] acc [NLANES];

  logic          start_ok;
  logic [3:0]    w_eff;
  logic [1:0]    k_eff;
  logic          accept;
  logic          last_pix;
  logic          last_lane;
  logic          last_strip;
  logic [DW-1:0] drain_raw;
  logic [DW-1:0] drain_val;

  // Job acceptance and config clamping: zero width/height jobs are dropped.
  assign start_ok   = start && (cfg_out_w != 4'd0) && (cfg_out_h != 8'd0);
  assign w_eff      = (cfg_out_w > 4'(NLANES)) ? 4'(NLANES) : cfg_out_w;
  assign k_eff      = (cfg_pool == 2'd0) ? 2'd1 : cfg_pool;

  assign accept     = in_valid && (state == S_ACCUM);
  assign last_pix   = accept && (kcol == cfg_k - 2'd1) && (lane == cfg_w - 4'd1)
                      && (krow == cfg_k - 2'd1);
  assign last_lane  = (drain_idx == cfg_w - 4'd1);
  assign last_strip = (strip == cfg_h - 8'd1);

  assign drain_raw  = acc[drain_idx];
`ifdef FS_ACCEL_MPCTRL_RELU_EN
  assign drain_val  = drain_raw[DW-1] ? '0 : drain_raw;
`else
  assign drain_val  = drain_raw;
`endif

  assign mp_sel    = lane;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_ACCUM;
      S_ACCUM: if (last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (out_ready && last_lane) state_nxt = last_strip ? S_DONE : S_ACCUM;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = ACC_INIT;
    out_lane  = 4'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_lane  = drain_idx;
        out_data  = drain_val;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: config latch, window counters, lane maxima and drain index.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_w     <= 4'd0;
      cfg_k     <= 2'd0;
      cfg_h     <= 8'd0;
      kcol      <= 2'd0;
      lane      <= 4'd0;
      krow      <= 2'd0;
      strip     <= 8'd0;
      drain_idx <= 4'd0;
      for (int i = 0; i < NLANES; i++) acc[i] <= ACC_INIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            cfg_w     <= w_eff;
            cfg_k     <= k_eff;
            cfg_h     <= cfg_out_h;
            kcol      <= 2'd0;
            lane      <= 4'd0;
            krow      <= 2'd0;
            strip     <= 8'd0;
            drain_idx <= 4'd0;
            for (int i = 0; i < NLANES; i++) acc[i] <= ACC_INIT;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if ($signed(in_data) > acc[lane]) acc[lane] <= $signed(in_data);
            // kcol wraps into lane, lane wraps into krow.
            if (kcol == cfg_k - 2'd1) begin
              kcol <= 2'd0;
              if (lane == cfg_w - 4'd1) begin
                lane <= 4'd0;
                if (krow == cfg_k - 2'd1) krow <= 2'd0;
                else                      krow <= krow + 2'd1;
              end else begin
                lane <= lane + 4'd1;
              end
            end else begin
              kcol <= kcol + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (last_lane) begin
              drain_idx <= 4'd0;
              if (last_strip) begin
                strip <= 8'd0;
              end else begin
                // Next strip starts from a clean identity in every lane.
                strip <= strip + 8'd1;
                for (int i = 0; i < NLANES; i++) acc[i] <= ACC_INIT;
              end
            end else begin
              drain_idx <= drain_idx + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fs_accel_mpctrl.sv
// tb_fs_accel_mpctrl: randomized self-checking bench for fs_accel_mpctrl.
// The reference computes each lane result directly as the maximum over its
// KxK window of a stored image, plus the expected lane order and mp_sel
// sequence; a negedge monitor compares the DUT against those queues.
module tb_fs_accel_mpctrl;

`ifdef FS_ACCEL_MPCTRL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       start;
  logic [3:0] cfg_out_w;
  logic [1:0] cfg_pool;
  logic [7:0] cfg_out_h;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] mp_sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_lane;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  fs_accel_mpctrl dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_out_w(cfg_out_w), .cfg_pool(cfg_pool), .cfg_out_h(cfg_out_h),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mp_sel(mp_sel), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .out_ready(out_ready), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [3:0] exp_lane_q[$];
  logic [3:0] mp_q[$];
  int         obs_q[$];
  int         obs_mp[$];

  int         img [16][39];
  bit         hold_bp = 1'b0;
  bit         done_pending = 1'b0;
  int         done_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [3:0] prev_l;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      chk("done", done, done_pending);
      if (done) done_cnt++;
      done_pending = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_lane", out_lane, prev_l);
      end
      if (in_valid && in_ready) begin
        if (mp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pixel: actual accept, required none");
        end else begin
          chk("mp_sel", mp_sel, mp_q.pop_front());
        end
        obs_mp.push_back(int'(mp_sel));
      end
      if (out_valid) begin
        chk("in_ready_in_drain", in_ready, 0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: actual lane %0d data %0d, required none", out_lane, out_data);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
            chk("out_lane", out_lane, exp_lane_q.pop_front());
            if (exp_q.size() == 0) done_pending = 1'b1;
          end
          obs_q.push_back(int'($signed(out_data)));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_lane;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input int w, input int k, input int h,
                         input int abort_at, input bit bp, input bit dbl);
    int  kk, ww, m, idx, budget, d0;
    bit  got;
    kk = (k == 0) ? 1 : k;
    ww = (w > 13) ? 13 : w;
    // Reference: each lane is the max of its KxK window in the strip.
    for (int s = 0; s < h; s++) begin
      for (int l = 0; l < ww; l++) begin
        m = -128;
        for (int r = 0; r < kk; r++)
          for (int c = 0; c < kk; c++)
            if (img[s*kk + r][l*kk + c] > m) m = img[s*kk + r][l*kk + c];
        if (RELU && m < 0) m = 0;
        exp_q.push_back(8'(m));
        exp_lane_q.push_back(4'(l));
      end
      for (int r = 0; r < kk; r++)
        for (int c = 0; c < ww*kk; c++)
          mp_q.push_back(4'(c / kk));
    end
    obs_q.delete();
    obs_mp.delete();
    d0 = done_cnt;

    start = 1'b1; cfg_out_w = 4'(w); cfg_pool = 2'(k); cfg_out_h = 8'(h);
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0;
    for (int s = 0; s < h; s++) begin
      for (int r = 0; r < kk; r++) begin
        for (int c = 0; c < ww*kk; c++) begin
          if (idx == abort_at) begin
            in_valid = 1'b0;
            resetn = 1'b0;
            @(posedge clk); #1;
            resetn = 1'b1;
            mp_q.delete(); exp_q.delete(); exp_lane_q.delete();
            @(negedge clk);
            chk("busy_after_reset", busy, 0);
            chk("out_valid_after_reset", out_valid, 0);
            chk("in_ready_after_reset", in_ready, 0);
            return;
          end
          if (bp && s == h-1 && r == kk-1 && c == ww*kk-1) hold_bp = 1'b1;
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          in_valid = 1'b1;
          in_data  = 8'(img[s*kk + r][c]);
          if (dbl && idx == 1) begin start = 1'b1; cfg_out_w = 4'd5; cfg_pool = 2'd1; end
          budget = 0;
          do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            budget++;
          end while (!got && budget < 600);
          start = 1'b0;
          if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL pixel_timeout: actual no accept, required accept within 600 cycles");
          end
          idx++;
        end
      end
    end
    in_valid = 1'b0;

    if (bp) begin
      budget = 0;
      do begin @(negedge clk); budget++; end while (!out_valid && budget < 50);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_lane", out_lane, 0);
        chk("bp_in_ready", in_ready, 0);
      end
      hold_bp = 1'b0;
    end

    budget = 0;
    while (done_cnt == d0 && budget < 4000) begin @(negedge clk); budget++; end
    if (done_cnt == d0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: actual no done, required done within 4000 cycles");
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic fill_random(input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < 39; c++)
        img[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mp_exp [8];
    int w, k, h;
    resetn = 1'b0; start = 1'b0; cfg_out_w = '0; cfg_pool = '0; cfg_out_h = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h80);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_mp_sel", mp_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Zero-width and zero-height jobs are ignored.
    start = 1'b1; cfg_out_w = 4'd0; cfg_pool = 2'd2; cfg_out_h = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("ign_w0_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b1; cfg_out_w = 4'd2; cfg_pool = 2'd2; cfg_out_h = 8'd0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("ign_h0_busy", busy, 0);
    chk("ign_h0_in_ready", in_ready, 0);
    @(posedge clk); #1;

    // K=2, out_w=2, out_h=1 directed job.
    img[0][0] = 1; img[0][1] = 5; img[0][2] = -3; img[0][3] = -7;
    img[1][0] = 2; img[1][1] = 0; img[1][2] = -9; img[1][3] = -4;
    run_job(2, 2, 1, -1, 1'b0, 1'b0);
    mp_exp = '{0, 0, 1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) chk("lit_mp_seq", obs_mp[i], mp_exp[i]);
    chk("lit_k2_lane0", obs_q[0], 5);
    chk("lit_k2_lane1", obs_q[1], RELU ? 0 : -3);

    // K=3, out_w=13: a single 42 in the last window, with backpressure.
    for (int r = 0; r < 3; r++) for (int c = 0; c < 39; c++) img[r][c] = -128;
    img[2][38] = 42;
    run_job(13, 3, 1, -1, 1'b1, 1'b0);
    for (int l = 0; l < 12; l++) chk("lit_k3_low_lane", obs_q[l], RELU ? 0 : -128);
    chk("lit_k3_lane12", obs_q[12], 42);

    // Two strips: accumulators must restart from the identity.
    img[0][0] = 10; img[0][1] = 20; img[1][0] = 30; img[1][1] = 40;
    img[2][0] = -5; img[2][1] = -6; img[3][0] = -7; img[3][1] = -8;
    run_job(1, 2, 2, -1, 1'b0, 1'b0);
    chk("lit_strip0", obs_q[0], 40);
    chk("lit_strip1", obs_q[1], RELU ? 0 : -5);

    // All-negative window: ReLU clamps, raw build passes the max through.
    img[0][0] = -1; img[0][1] = -2; img[1][0] = -3; img[1][1] = -4;
    run_job(1, 2, 1, -1, 1'b0, 1'b0);
    chk("lit_relu", obs_q[0], RELU ? 0 : -1);

    // Reset mid-ACCUM, then the same job clean.
    fill_random(4);
    run_job(5, 2, 2, 7, 1'b0, 1'b0);
    run_job(5, 2, 2, -1, 1'b0, 1'b0);

    // Randomized jobs, including clamped widths, K=0 and ignored restarts.
    for (int j = 0; j < 25; j++) begin
      w = $urandom_range(1, 15);
      k = $urandom_range(0, 3);
      h = $urandom_range(1, 3);
      fill_random(9);
      run_job(w, k, h, -1, 1'b0, ($urandom_range(0, 3) == 0));
    end

    chk("queues_drained", exp_q.size() + mp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fs_accel_mpctrl.md
Name: fs_accel_mpctrl

Overview:
- Max-pool window scheduler and accumulator for the CNN accelerator.
- Accepts an int8 feature-map stream in row-major order and steers each pixel to one of up to 13 lane accumulators via a 4-bit select.
- Non-selected lanes see the max identity (-128); each lane keeps a running signed max over its KxK window.
- After every K-row strip, drains the lane results in order over a valid/ready output port.

Parameters:
- NLANES, 13, number of output columns per strip, i.e. lane accumulators. mp_sel range is 0..NLANES-1.
- DW, 8, pixel width. Signed two's complement.

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  reset
- start  input  1  one-cycle pulse; latches cfg_* and begins a pooling job
- cfg_out_w  input  4  output columns per strip (1..NLANES)
- cfg_pool  input  2  pool size K (1..3)
- cfg_out_h  input  8  output rows (strips) per job (1..255)
- in_valid  input  1  input pixel valid
- in_data  input  DW  signed input pixel
- in_ready  output  1  block accepts pixel
- mp_sel  output  4  lane index of the current input pixel (col / K)
- out_valid  output  1  pooled result valid
- out_data  output  DW  signed pooled result
- out_lane  output  4  lane index of out_data
- out_ready  input  1  downstream accepts result
- busy  output  1  job in progress
- done  output  1  one-cycle pulse at job end

Behaviour:
- Reset: resetn is synchronous, active-low. On reset:
  - state IDLE; all counters 0; all lane accumulators -128.
  - in_ready=0, out_valid=0, out_data=-128, out_lane=0, mp_sel=0, busy=0, done=0.
- Reset mid-job: abandons the job immediately, with the same values as above. No partial drain.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 latches the config and sets all accumulators to -128; next state ACCUM.
  - Config clamping: cfg_out_w=0 -> start ignored; cfg_out_w>NLANES -> NLANES; cfg_pool=0 -> K=1; cfg_out_h=0 -> start ignored.
- ACCUM:
  - in_ready=1; busy=1.
  - Pixel accepted on in_valid&&in_ready.
  - Counters: kcol (0..K-1), lane (0..out_w-1), krow (0..K-1). kcol wraps into lane; lane wraps into krow.
  - mp_sel=lane, combinational from registered counters.
  - Accepted pixel updates acc[lane] <= max_signed(acc[lane], in_data) at the same edge; visible the next cycle.
  - Accepting the last pixel of a strip (kcol=K-1, lane=out_w-1, krow=K-1) moves to DRAIN.
- DRAIN:
  - in_ready=0 (input stalled); out_valid=1.
  - out_lane=drain_idx; out_data=acc[drain_idx].
  - First result is presented the cycle after the last pixel is accepted, and includes that pixel.
  - drain_idx advances on out_valid&&out_ready.
  - While out_valid&&!out_ready, out_data and out_lane are held stable.
  - After the handshake on lane out_w-1:
    - if strip=out_h-1 -> DONE;
    - else strip+1, all accumulators reset to -128 at that edge, counters 0, -> ACCUM.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
- start while busy: ignored.
- in_valid while not in ACCUM: ignored; no pixel consumed.
- Lanes >= out_w are never selected and never drained.
- Max compare is signed 8-bit; -128 is the identity value; no saturation needed.

Optional Feature:
- Macro: FS_ACCEL_MPCTRL_RELU_EN
- Defined: out_data = (acc < 0) ? 0 : acc. ReLU fused into the drain; accumulator contents are unchanged.
- Undefined: out_data = acc, raw signed max.

Test Plan:
- K=2, out_w=2, out_h=1; pixels row0 {1,5,-3,-7}, row1 {2,0,-9,-4}:
  - mp_sel sequence 0,0,1,1,0,0,1,1;
  - outputs lane0=5, lane1=-3;
  - done pulses 1 cycle after the lane1 handshake.
- K=3, out_w=13, out_h=1; all pixels -128 except one 42 at row2, col 38:
  - lane12=42; all other lanes -128;
  - in_ready=0 throughout the drain.
- Backpressure: during DRAIN hold out_ready=0 for 5 cycles -> out_valid stays 1 with out_data/out_lane constant; no input accepted.
- out_h=2, K=2, out_w=1:
  - strip0 pixels {10,20,30,40} -> output 40;
  - strip1 pixels {-5,-6,-7,-8} -> output -5, proving accumulators were re-initialised to -128.
- resetn=0 for one cycle mid-ACCUM, then a new start with the same job:
  - no stale output appears;
  - results match a clean run; busy=0 right after the reset cycle.
- FS_ACCEL_MPCTRL_RELU_EN defined, K=2, out_w=1, pixels {-1,-2,-3,-4} -> out_data=0; undefined -> out_data=-1.
